cmd_bank_queue: RTL and testbench
=================================

Name: cmd_bank_queue

Overview:
- Command front-end of the DRAM controller. Sits directly downstream of the host/pattern command source.
- Accepts the 36-bit access command, its valid strobe and the 128-bit write data. Sorts each command into a per-bank FIFO.
- Returns per-bank back-pressure on ba_cmd_pm.
- Issues queued commands one at a time, round-robin across banks, to the controller scheduler over a valid/ready port.

Parameters:
- NB, 4, number of bank queues. Bank index = command[1:0].
- DEPTH, 4, entries per bank FIFO (power of 2, >=2).
- CMD_W, 36, command width. Layout: {rank[35:33], rw_ctl[32:31], 0, row[29:17], 0, bl[15], 0, auto_pre[13], col[12:3], bank[2:0]}.
- DATA_W, 128, write-data width (DQ_BITS*8).

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- power_on_rst, input, 1, asynchronous active-high reset.
- command, input, CMD_W, access command from upstream.
- valid, input, 1, command qualifier.
- write_data, input, DATA_W, write payload; meaningful only when rw_ctl=00.
- ba_cmd_pm, output, NB, bit b=1 when bank-b queue can accept a command.
- out_valid, output, 1, issue port holds a command.
- out_cmd, output, CMD_W, issued command.
- out_wdata, output, DATA_W, issued write payload (0 for reads).
- out_ready, input, 1, scheduler takes the issued command.
- drop_err, output, 1, one-cycle pulse on a rejected command.

Behaviour:
- Reset (async, power_on_rst=1):
  - all FIFO counts = 0, round-robin pointer = 0;
  - out_valid = 0, out_cmd = 0, out_wdata = 0, drop_err = 0;
  - ba_cmd_pm = all ones, because it is derived from the counts.
  - Reset asserted mid-operation discards all queued and staged commands immediately.
- Classification at a rising edge with valid=1:
  - rw_ctl=00 is a write, 01 is a read.
  - rw_ctl=10 or 11 is a NOP: not queued, no error.
  - command[2]=1 (bank >= 4) is not queued: drop_err=1 next cycle.
  - Otherwise the target is queue q = command[1:0].
- Push rule:
  - Accept when count[q] < DEPTH. Store {command, write_data}; store write_data as 0 when rw_ctl != 00.
  - If count[q] == DEPTH, the command is lost: drop_err=1 next cycle, no state change.
  - A pop from q in the same edge does not allow a push into a full q.
- ba_cmd_pm[b] = (count[b] < DEPTH), combinational from registered counts. Upstream launches on the falling edge, so the value is stable half a cycle before sampling.
- Output stage: one register slice.
  - Load when out_valid=0 or (out_valid & out_ready).
  - Winner = first non-empty queue scanning from rr_ptr upward, modulo NB.
  - After a load, rr_ptr = winner+1 (mod NB). rr_ptr holds when nothing is loaded.
  - If out_valid & out_ready and all queues are empty, out_valid -> 0 and out_cmd/out_wdata hold their last value.
  - out_cmd/out_wdata are stable while out_valid=1 & out_ready=0.
- Latency: a command accepted at edge N into an empty block has out_valid=1 after edge N+1.
- Simultaneous push and pop on the same queue is allowed when count < DEPTH; the count is unchanged.
- Ordering: per-bank order is strictly FIFO. Cross-bank order follows round-robin only.
- FIFO pointers wrap modulo DEPTH.

Optional Feature:
- Macro: CMD_STATS_EN.
- When defined, adds outputs stat_wr[31:0], stat_rd[31:0], stat_nop[31:0] and stat_drop[31:0].
  - Each counts accepted writes, accepted reads, NOPs and drops respectively.
  - Each is reset to 0 and saturates at 0xFFFFFFFF.
- When undefined, these ports and counters do not exist and the behaviour is otherwise identical.

Test Plan:
- Reset then idle:
  - ba_cmd_pm=4'b1111, out_valid=0, drop_err=0.
- Single write, row 0, col 8, bank 1, write_data=128'hA5..A5, out_ready=1:
  - out_valid=1 one edge after acceptance;
  - out_cmd equals the input; out_wdata=A5..A5.
- Five reads to bank 2 with out_ready=0:
  - ba_cmd_pm[2]=0 after the 4th;
  - the 5th raises drop_err for one cycle; the other bits stay 1.
- Reads to banks 0, 1, 3 queued together with out_ready=1:
  - issue order is 0, 1, 3, then rr_ptr=0.
  - A new bank-0 read pushed while bank 3 is issuing is issued after bank 3.
- NOP (rw_ctl=10) with valid=1:
  - nothing issued, no drop_err; stat_nop increments when CMD_STATS_EN is defined.
- Assert power_on_rst with 3 queued commands and out_valid=1:
  - out_valid=0 immediately; after release nothing is issued and ba_cmd_pm=4'b1111.

Source files
------------

// File: rtl/cmd_bank_queue.sv
// -----------------------------------------------------------------------------
// cmd_bank_queue -- DRAM controller command front-end.
//
// Sorts incoming access commands into per-bank FIFOs. Then it issues them one
// at a time, round-robin across banks, through a single register slice with a
// valid/ready handshake.
//
// Ports
//   clk           system clock, all state changes on the rising edge
//   power_on_rst  asynchronous active-high reset
//   command       36-bit access command:
//                 {rank, rw_ctl, 0, row, 0, bl, 0, auto_pre, col, bank}
//   valid         command qualifier
//   write_data    write payload; meaningful only for writes (rw_ctl=00)
//   ba_cmd_pm     per-bank "queue can accept" flags, from registered counts
//   out_valid     the issue slice holds a command
//   out_cmd       issued command
//   out_wdata     issued write payload; zero for reads
//   out_ready     scheduler takes the issued command
//   drop_err      one-cycle pulse for a command that was rejected
//
// Optional build macro CMD_STATS_EN adds four saturating 32-bit counters:
//   stat_wr, stat_rd, stat_nop and stat_drop.
// -----------------------------------------------------------------------------
module cmd_bank_queue #(
  parameter int NB     = 4,
  parameter int DEPTH  = 4,
  parameter int CMD_W  = 36,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              power_on_rst,
  input  logic [CMD_W-1:0]  command,
  input  logic              valid,
  input  logic [DATA_W-1:0] write_data,
  output logic [NB-1:0]     ba_cmd_pm,
  output logic              out_valid,
  output logic [CMD_W-1:0]  out_cmd,
  output logic [DATA_W-1:0] out_wdata,
  input  logic              out_ready,
  output logic              drop_err
`ifdef CMD_STATS_EN
  ,
  output logic [31:0]       stat_wr,
  output logic [31:0]       stat_rd,
  output logic [31:0]       stat_nop,
  output logic [31:0]       stat_drop
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int QI_W  = $clog2(NB);

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [DATA_W-1:0] wdata;
  } entry_t;

  // Wraps a queue index modulo NB. This also works when NB is not a power of 2.
  function automatic logic [QI_W-1:0] rr_idx(input logic [QI_W-1:0] base, input int k);
    return QI_W'((int'(base) + k) % NB);
  endfunction

  entry_t            mem_q    [NB][DEPTH];
  logic [CNT_W-1:0]  count_q  [NB];
  logic [CNT_W-1:0]  count_d  [NB];
  logic [PTR_W-1:0]  wr_ptr_q [NB];
  logic [PTR_W-1:0]  rd_ptr_q [NB];
  logic [QI_W-1:0]   rr_ptr_q;
  logic              out_valid_q;
  logic [CMD_W-1:0]  out_cmd_q;
  logic [DATA_W-1:0] out_wdata_q;
  logic              drop_err_q;

  logic              is_nop, is_wr, bad_bank, push_req, q_full, push_ok, drop;
  logic [QI_W-1:0]   q_idx;
  logic              load_en, win_found, pop;
  logic [QI_W-1:0]   win_idx;
  entry_t            head;

  // ---- classification and push decision ------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    is_nop   = command[32];                 // rw_ctl = 1x
    is_wr    = (command[32:31] == 2'b00);
    bad_bank = (32'(command[2:0]) >= 32'(NB));
    q_idx    = command[QI_W-1:0];
    push_req = valid && !is_nop && !bad_bank;
    // A full queue is judged on the registered count. A pop from the same
    // queue on this edge never makes room for the push.
    q_full   = (count_q[q_idx] == CNT_W'(DEPTH));
    push_ok  = push_req && !q_full;
    drop     = valid && !is_nop && (bad_bank || (push_req && q_full));
  end

  // ---- round-robin winner and issue-slice load --------------------------------
  always_comb begin
    load_en   = !out_valid_q || out_ready;
    win_found = 1'b0;
    win_idx   = rr_ptr_q;
    for (int k = 0; k < NB; k++) begin
      if (!win_found && count_q[rr_idx(rr_ptr_q, k)] != '0) begin
        win_found = 1'b1;
        win_idx   = rr_idx(rr_ptr_q, k);
      end
    end
    pop  = load_en && win_found;
    head = mem_q[win_idx][rd_ptr_q[win_idx]];
  end

  always_comb begin
    for (int b = 0; b < NB; b++) begin
      count_d[b] = count_q[b];
      if (push_ok && q_idx == QI_W'(b)) count_d[b] = count_d[b] + 1'b1;
      if (pop && win_idx == QI_W'(b))   count_d[b] = count_d[b] - 1'b1;
    end
  end

  // NOTE: FIFO storage has no reset. Reset clears the counts and pointers,
  // which makes every stored entry invisible. Resetting the array would only
  // add a reset fan-out to a large block of flops.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[q_idx][wr_ptr_q[q_idx]] <= '{cmd: command, wdata: is_wr ? write_data : '0};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // process sees the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or posedge power_on_rst) begin
    if (power_on_rst) begin
      for (int b = 0; b < NB; b++) begin
        count_q[b]  <= '0;
        wr_ptr_q[b] <= '0;
        rd_ptr_q[b] <= '0;
      end
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_cmd_q   <= '0;
      out_wdata_q <= '0;
      drop_err_q  <= 1'b0;
    end else begin
      for (int b = 0; b < NB; b++) count_q[b] <= count_d[b];
      if (push_ok) wr_ptr_q[q_idx] <= wr_ptr_q[q_idx] + 1'b1;
      if (pop) begin
        rd_ptr_q[win_idx] <= rd_ptr_q[win_idx] + 1'b1;
        rr_ptr_q          <= rr_idx(win_idx, 1);
        out_valid_q       <= 1'b1;
        out_cmd_q         <= head.cmd;
        out_wdata_q       <= head.wdata;
      end else if (load_en) begin
        // The slice was taken (or was already empty) and nothing is queued.
        // The data fields keep their last value.
        out_valid_q <= 1'b0;
      end
      drop_err_q <= drop;
    end
  end

  always_comb begin
    for (int b = 0; b < NB; b++) ba_cmd_pm[b] = (count_q[b] < CNT_W'(DEPTH));
  end

  assign out_valid = out_valid_q;
  assign out_cmd   = out_cmd_q;
  assign out_wdata = out_wdata_q;
  assign drop_err  = drop_err_q;

`ifdef CMD_STATS_EN
  logic [31:0] stat_wr_q, stat_rd_q, stat_nop_q, stat_drop_q;

  always_ff @(posedge clk or posedge power_on_rst) begin
    if (power_on_rst) begin
      stat_wr_q   <= '0;
      stat_rd_q   <= '0;
      stat_nop_q  <= '0;
      stat_drop_q <= '0;
    end else begin
      if (push_ok && is_wr && stat_wr_q != '1)    stat_wr_q   <= stat_wr_q + 1'b1;
      if (push_ok && !is_wr && stat_rd_q != '1)   stat_rd_q   <= stat_rd_q + 1'b1;
      if (valid && is_nop && stat_nop_q != '1)    stat_nop_q  <= stat_nop_q + 1'b1;
      if (drop && stat_drop_q != '1)              stat_drop_q <= stat_drop_q + 1'b1;
    end
  end

  assign stat_wr   = stat_wr_q;
  assign stat_rd   = stat_rd_q;
  assign stat_nop  = stat_nop_q;
  assign stat_drop = stat_drop_q;
`endif

endmodule

// File: tb/tb_cmd_bank_queue.sv
// -----------------------------------------------------------------------------
// tb_cmd_bank_queue -- directed self-checking bench for cmd_bank_queue.
// Inputs change on the falling edge, matching the upstream source.
// Outputs are sampled on the falling edge that follows each rising edge.
// -----------------------------------------------------------------------------
module tb_cmd_bank_queue;

  logic          clk = 1'b0;
  logic          power_on_rst;
  logic [35:0]   command;
  logic          valid;
  logic [127:0]  write_data;
  logic [3:0]    ba_cmd_pm;
  logic          out_valid;
  logic [35:0]   out_cmd;
  logic [127:0]  out_wdata;
  logic          out_ready;
  logic          drop_err;
`ifdef CMD_STATS_EN
  logic [31:0]   stat_wr, stat_rd, stat_nop, stat_drop;
`endif

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] WD_A5  = {16{8'hA5}};
  localparam logic [127:0] WD_JNK = {4{32'hDEADBEEF}};

  always #5 clk = ~clk;

  cmd_bank_queue dut (
    .clk          (clk),
    .power_on_rst (power_on_rst),
    .command      (command),
    .valid        (valid),
    .write_data   (write_data),
    .ba_cmd_pm    (ba_cmd_pm),
    .out_valid    (out_valid),
    .out_cmd      (out_cmd),
    .out_wdata    (out_wdata),
    .out_ready    (out_ready),
    .drop_err     (drop_err)
`ifdef CMD_STATS_EN
    ,
    .stat_wr      (stat_wr),
    .stat_rd      (stat_rd),
    .stat_nop     (stat_nop),
    .stat_drop    (stat_drop)
`endif
  );

  function automatic logic [35:0] mk_cmd(input logic [2:0] rank, input logic [1:0] rw,
                                         input logic [12:0] row, input logic [9:0] col,
                                         input logic [2:0] bank);
    return {rank, rw, 1'b0, row, 1'b0, 1'b0, 1'b0, 1'b0, col, bank};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    power_on_rst = 1'b1;
    valid        = 1'b0;
    out_ready    = 1'b0;
    @(negedge clk);
    power_on_rst = 1'b0;
    @(negedge clk);
  endtask

  // Presents one command for exactly one rising edge and returns on the next
  // falling edge.
  task automatic drive(input logic [35:0] c, input logic [127:0] wd);
    command    = c;
    write_data = wd;
    valid      = 1'b1;
    @(negedge clk);
    valid      = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (ba_cmd_pm !== 4'b1111) begin bad++; $display("FAIL reset_pm got=%b exp=1111", ba_cmd_pm); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (drop_err !== 1'b0) begin bad++; $display("FAIL reset_drop got=%b exp=0", drop_err); end
    total++; if (out_cmd !== 36'h0) begin bad++; $display("FAIL reset_cmd got=%h exp=0", out_cmd); end
    total++; if (out_wdata !== 128'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", out_wdata); end
  endtask

  task automatic test_single_write();
    logic [35:0] c;
    do_reset();
    out_ready = 1'b1;
    c = mk_cmd(3'd0, 2'b00, 13'd0, 10'd8, 3'd1);
    drive(c, WD_A5);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL wr_latency got=%b exp=0", out_valid); end
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL wr_valid got=%b exp=1", out_valid); end
    total++; if (out_cmd !== c) begin bad++; $display("FAIL wr_cmd got=%h exp=%h", out_cmd, c); end
    total++; if (out_wdata !== WD_A5) begin bad++; $display("FAIL wr_wdata got=%h exp=%h", out_wdata, WD_A5); end
`ifdef CMD_STATS_EN
    total++; if (stat_wr !== 32'd1) begin bad++; $display("FAIL stat_wr got=%0d exp=1", stat_wr); end
`endif
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL wr_drain got=%b exp=0", out_valid); end
    total++; if (out_cmd !== c) begin bad++; $display("FAIL wr_hold got=%h exp=%h", out_cmd, c); end
  endtask

  task automatic test_full_bank();
    logic [35:0] c0, rd [4], rd5, rdw;
    do_reset();
    out_ready = 1'b0;
    c0 = mk_cmd(3'd0, 2'b01, 13'd5, 10'd16, 3'd0);
    for (int i = 0; i < 4; i++) rd[i] = mk_cmd(3'd1, 2'b01, 13'(10 + i), 10'(100 + i), 3'd2);
    rd5 = mk_cmd(3'd1, 2'b01, 13'd20, 10'd200, 3'd2);
    rdw = mk_cmd(3'd2, 2'b01, 13'd30, 10'd300, 3'd2);
    // The bank-0 read occupies the stalled slice, so the bank-2 reads stay queued.
    drive(c0, WD_JNK);
    for (int i = 0; i < 4; i++) begin
      drive(rd[i], WD_JNK);
      total++;
      if (ba_cmd_pm !== ((i == 3) ? 4'b1011 : 4'b1111)) begin
        bad++; $display("FAIL fill_pm_%0d got=%b", i, ba_cmd_pm);
      end
    end
    total++; if (out_cmd !== c0 || out_valid !== 1'b1) begin bad++; $display("FAIL stall_cmd got=%h exp=%h", out_cmd, c0); end
    total++; if (out_wdata !== 128'h0) begin bad++; $display("FAIL rd_wdata got=%h exp=0", out_wdata); end
    drive(rd5, WD_JNK);
    total++; if (drop_err !== 1'b1) begin bad++; $display("FAIL full_drop got=%b exp=1", drop_err); end
    total++; if (ba_cmd_pm !== 4'b1011) begin bad++; $display("FAIL full_pm got=%b exp=1011", ba_cmd_pm); end
    @(negedge clk);
    total++; if (drop_err !== 1'b0) begin bad++; $display("FAIL drop_pulse got=%b exp=0", drop_err); end
    total++; if (out_cmd !== c0) begin bad++; $display("FAIL stall_stable got=%h exp=%h", out_cmd, c0); end
    // The pop and the push into the full queue happen on the same edge.
    // The push must still be rejected.
    out_ready = 1'b1;
    drive(rd5, WD_JNK);
    total++; if (drop_err !== 1'b1) begin bad++; $display("FAIL popfull_drop got=%b exp=1", drop_err); end
    total++; if (out_cmd !== rd[0]) begin bad++; $display("FAIL fifo_0 got=%h exp=%h", out_cmd, rd[0]); end
    total++; if (ba_cmd_pm !== 4'b1111) begin bad++; $display("FAIL popfull_pm got=%b exp=1111", ba_cmd_pm); end
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      total++; if (out_cmd !== rd[i] || out_valid !== 1'b1) begin bad++; $display("FAIL fifo_%0d got=%h exp=%h", i, out_cmd, rd[i]); end
    end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fifo_empty got=%b exp=0", out_valid); end
    // Both pointers of bank 2 have wrapped, so the next entry must issue correctly.
    drive(rdw, WD_JNK);
    @(negedge clk);
    total++; if (out_cmd !== rdw || out_valid !== 1'b1) begin bad++; $display("FAIL wrap got=%h exp=%h", out_cmd, rdw); end
  endtask

  task automatic test_round_robin();
    logic [35:0] b0, b1, b3, b0n;
    do_reset();
    out_ready = 1'b0;
    b0  = mk_cmd(3'd0, 2'b01, 13'd1, 10'd1, 3'd0);
    b1  = mk_cmd(3'd0, 2'b01, 13'd2, 10'd2, 3'd1);
    b3  = mk_cmd(3'd0, 2'b01, 13'd3, 10'd3, 3'd3);
    b0n = mk_cmd(3'd0, 2'b01, 13'd4, 10'd4, 3'd0);
    drive(b0, WD_JNK);
    drive(b1, WD_JNK);
    drive(b3, WD_JNK);
    total++; if (out_cmd !== b0) begin bad++; $display("FAIL rr_0 got=%h exp=%h", out_cmd, b0); end
    // Bank 0 refills while bank 1 issues. Bank 3 must still come before it.
    out_ready = 1'b1;
    drive(b0n, WD_JNK);
    total++; if (out_cmd !== b1) begin bad++; $display("FAIL rr_1 got=%h exp=%h", out_cmd, b1); end
    @(negedge clk);
    total++; if (out_cmd !== b3) begin bad++; $display("FAIL rr_3 got=%h exp=%h", out_cmd, b3); end
    @(negedge clk);
    total++; if (out_cmd !== b0n || out_valid !== 1'b1) begin bad++; $display("FAIL rr_0n got=%h exp=%h", out_cmd, b0n); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rr_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_nop_bad_bank();
    do_reset();
    out_ready = 1'b1;
    drive(mk_cmd(3'd0, 2'b10, 13'd7, 10'd7, 3'd1), WD_A5);
    total++; if (drop_err !== 1'b0) begin bad++; $display("FAIL nop_drop got=%b exp=0", drop_err); end
    drive(mk_cmd(3'd0, 2'b11, 13'd7, 10'd7, 3'd6), WD_A5);
    total++; if (drop_err !== 1'b0) begin bad++; $display("FAIL nop_bank6 got=%b exp=0", drop_err); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL nop_issue got=%b exp=0", out_valid); end
    drive(mk_cmd(3'd0, 2'b01, 13'd7, 10'd7, 3'd5), WD_A5);
    total++; if (drop_err !== 1'b1) begin bad++; $display("FAIL bank5_drop got=%b exp=1", drop_err); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || ba_cmd_pm !== 4'b1111) begin bad++; $display("FAIL bank5_queued got=%b/%b exp=0/1111", out_valid, ba_cmd_pm); end
`ifdef CMD_STATS_EN
    total++; if (stat_nop !== 32'd2) begin bad++; $display("FAIL stat_nop got=%0d exp=2", stat_nop); end
    total++; if (stat_drop !== 32'd1) begin bad++; $display("FAIL stat_drop got=%0d exp=1", stat_drop); end
    total++; if (stat_rd !== 32'd0) begin bad++; $display("FAIL stat_rd got=%0d exp=0", stat_rd); end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    for (int b = 0; b < 4; b++) drive(mk_cmd(3'd0, 2'b01, 13'(b), 10'(b), 3'(b)), WD_JNK);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_pre got=%b exp=1", out_valid); end
    power_on_rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_async got=%b exp=0", out_valid); end
    total++; if (out_cmd !== 36'h0) begin bad++; $display("FAIL mid_cmd got=%h exp=0", out_cmd); end
    @(negedge clk);
    power_on_rst = 1'b0;
    out_ready    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_after_%0d got=%b exp=0", i, out_valid); end
    end
    total++; if (ba_cmd_pm !== 4'b1111) begin bad++; $display("FAIL mid_pm got=%b exp=1111", ba_cmd_pm); end
  endtask

  initial begin
    power_on_rst = 1'b1;
    valid        = 1'b0;
    out_ready    = 1'b0;
    command      = '0;
    write_data   = '0;
    test_reset();
    test_single_write();
    test_full_bank();
    test_round_robin();
    test_nop_bad_bank();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
